data_bus_master_arbiter: RTL
============================

Name: data_bus_master_arbiter

Overview:
- Shares the single-port data bus (address decoder plus main/heap memory, IO registers, palette and framebuffer port B) between NUM_MASTERS requesters, e.g. the display processor and a blitter/DMA engine.
- Uses round-robin arbitration with a bounded burst hold.
- Muxes the granted master's address, write data and write enables onto the bus, and returns one-cycle-latency read data tagged to the master that issued the read.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (2..8); index 0 has the highest priority after reset.
- MAX_BURST, 4, maximum consecutive granted cycles for one master while another master is requesting (1..255).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- m_req  input  NUM_MASTERS  per-master access request; held high until granted.
- m_addr  input  NUM_MASTERS*32  per-master byte address; master i uses bits [32i+31:32i].
- m_wr_data  input  NUM_MASTERS*32  per-master write data.
- m_wr_en  input  NUM_MASTERS*4  per-master byte write enables; all zero means a read.
- m_gnt  output  NUM_MASTERS  one-hot grant; the access is performed in any cycle where m_req[i]&m_gnt[i].
- m_rd_data  output  32  read data, shared by all masters.
- m_rd_valid  output  NUM_MASTERS  one-hot; m_rd_data belongs to master i this cycle.
- bus_valid  output  1  an access is on the bus this cycle.
- bus_addr  output  32  address to the bus decoder.
- bus_wr_data  output  32  write data to the bus decoder.
- bus_wr_en  output  4  byte write enables to the bus decoder.
- bus_rd_data  input  32  read data from the bus decoder, valid one cycle after the address.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - owner = none, rr_ptr = 0, burst_cnt = 0, rd_pending = 0.
  - All outputs 0: m_gnt, m_rd_valid, m_rd_data, bus_valid, bus_addr, bus_wr_data, bus_wr_en.
- Grant (combinational from registered state and m_req), decided each cycle:
  - If owner valid, m_req[owner]=1, and either (burst_cnt < MAX_BURST) or no other m_req bit is set: grant owner.
  - Otherwise grant the first requesting master found searching from rr_ptr upward, wrapping modulo NUM_MASTERS.
  - If no m_req bit is set, no grant.
- Registered update per cycle:
  - Grant to g: if g == owner, burst_cnt = burst_cnt+1, saturating at MAX_BURST. If no other master was requesting, burst_cnt = 1 (a lone master is never throttled). If g != owner, owner = g and burst_cnt = 1.
  - rr_ptr = (g+1) mod NUM_MASTERS whenever ownership changes.
  - No grant: owner = none, burst_cnt = 0, rr_ptr unchanged.
- Bus mux:
  - When granted, bus_valid=1 and bus_addr/bus_wr_data/bus_wr_en equal the granted master's signals.
  - Otherwise bus_valid=0 and all bus outputs are 0.
  - Non-granted masters' write enables never reach the bus.
- Read return:
  - rd_pending[g] <= granted & (m_wr_en[g]==0).
  - Next cycle: m_rd_valid = rd_pending and m_rd_data = bus_rd_data; otherwise m_rd_data = 0.
  - Latency is exactly 1 cycle. A master may issue back-to-back reads, one result per cycle.
- Writes complete in the grant cycle; no response is returned.
- A master dropping m_req mid-burst releases ownership that cycle; the grant moves to the next requester the same cycle with no idle cycle.
- If reset_n is asserted mid-burst, an in-flight read's m_rd_valid is suppressed. Arbitration restarts from master 0.
- The address decode and the region map are untouched by this block; unmapped addresses pass through unchanged.

Test Plan:
- Reset: hold reset_n=0 with m_req=2'b11 -> m_gnt=0, bus_valid=0, bus_wr_en=0, m_rd_valid=0; release -> master 0 granted first cycle.
- Single read latency: master 1 reads 32'h10000010 alone, bus_rd_data=32'hDEADBEEF next cycle -> m_gnt=2'b10 in cycle N, m_rd_valid=2'b10 and m_rd_data=32'hDEADBEEF in cycle N+1, zero in N+2.
- Burst limit: both request continuously, MAX_BURST=4 -> grants 0,0,0,0,1,1,1,1,0,...; m_rd_valid follows the same pattern one cycle later.
- Lone master: only master 0 requests for 10 cycles -> granted all 10; master 1 raises m_req at cycle 10 -> granted within MAX_BURST cycles.
- Write isolation: master 1 drives m_wr_en=4'hF to 32'hE0000000 while master 0 holds the grant -> bus_wr_en equals master 0's value; master 1's write appears only in its own grant cycle.
- Reset mid-burst: assert reset_n=0 in the cycle after a master 0 read grant -> m_rd_valid stays 0; after release, master 0 is granted first with burst_cnt restarted.

Source files
------------

// File: rtl/data_bus_master_arbiter.sv
// ============================================================================
// data_bus_master_arbiter: round-robin bus arbiter with burst hold and tagged 1-cycle read return
// Revision: 1.0
// ============================================================================
`default_nettype none

module data_bus_master_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int MAX_BURST   = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_MASTERS-1:0]   m_req,
  input  logic [NUM_MASTERS*32-1:0] m_addr,
  input  logic [NUM_MASTERS*32-1:0] m_wr_data,
  input  logic [NUM_MASTERS*4-1:0] m_wr_en,
  output logic [NUM_MASTERS-1:0]   m_gnt,
  output logic [31:0]              m_rd_data,
  output logic [NUM_MASTERS-1:0]   m_rd_valid,
  output logic                     bus_valid,
  output logic [31:0]              bus_addr,
  output logic [31:0]              bus_wr_data,
  output logic [3:0]               bus_wr_en,
  input  logic [31:0]              bus_rd_data
);

  localparam int         IW          = $clog2(NUM_MASTERS);
  localparam logic [7:0] C_MAX_BURST = 8'(MAX_BURST);

  logic                   owner_vld_q;
  logic [IW-1:0]          owner_q;
  logic [IW-1:0]          rr_ptr_q;
  logic [7:0]             burst_cnt_q;
  logic [NUM_MASTERS-1:0] rd_pending_q;

  logic                   keep_owner;
  logic                   found;
  logic [IW-1:0]          search_idx;
  logic [IW:0]            cand;
  logic                   gnt_vld;
  logic [IW-1:0]          gnt_idx;
  logic [NUM_MASTERS-1:0] gnt_oh;
  logic                   others_req;

  // Owner keeps the bus until its burst budget runs out, unless nobody else wants it.
  always_comb begin
    keep_owner = 1'b0;
    if (owner_vld_q && m_req[owner_q]) begin
      keep_owner = (burst_cnt_q < C_MAX_BURST) ||
                   ((m_req & ~(NUM_MASTERS'(1) << owner_q)) == '0);
    end
  end

  always_comb begin
    found      = 1'b0;
    search_idx = '0;
    cand       = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      cand = {1'b0, rr_ptr_q} + (IW+1)'(k);
      if (cand >= (IW+1)'(NUM_MASTERS)) cand = cand - (IW+1)'(NUM_MASTERS);
      if (!found && m_req[cand[IW-1:0]]) begin
        found      = 1'b1;
        search_idx = cand[IW-1:0];
      end
    end
  end

  // Grant is forced off while reset is held so nothing reaches the bus.
  assign gnt_vld    = reset_n && (keep_owner || found);
  assign gnt_idx    = keep_owner ? owner_q : search_idx;
  assign gnt_oh     = gnt_vld ? (NUM_MASTERS'(1) << gnt_idx) : '0;
  assign others_req = (m_req & ~gnt_oh) != '0;

  assign m_gnt       = gnt_oh;
  assign bus_valid   = gnt_vld;
  assign bus_addr    = gnt_vld ? m_addr[gnt_idx*32 +: 32]    : '0;
  assign bus_wr_data = gnt_vld ? m_wr_data[gnt_idx*32 +: 32] : '0;
  assign bus_wr_en   = gnt_vld ? m_wr_en[gnt_idx*4 +: 4]     : '0;

  assign m_rd_valid = rd_pending_q;
  assign m_rd_data  = (rd_pending_q != '0) ? bus_rd_data : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_vld_q  <= 1'b0;
      owner_q      <= '0;
      rr_ptr_q     <= '0;
      burst_cnt_q  <= '0;
      rd_pending_q <= '0;
    end else begin
      rd_pending_q <= (gnt_vld && (m_wr_en[gnt_idx*4 +: 4] == 4'h0)) ? gnt_oh : '0;
      if (!gnt_vld) begin
        owner_vld_q <= 1'b0;
        burst_cnt_q <= '0;
      end else if (owner_vld_q && (gnt_idx == owner_q)) begin
        if (!others_req)
          burst_cnt_q <= 8'd1;
        else if (burst_cnt_q < C_MAX_BURST)
          burst_cnt_q <= burst_cnt_q + 8'd1;
      end else begin
        owner_vld_q <= 1'b1;
        owner_q     <= gnt_idx;
        burst_cnt_q <= 8'd1;
        rr_ptr_q    <= (gnt_idx == IW'(NUM_MASTERS-1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire
